// File: rtl/seq_match_ctrl.sv
// seq_match_ctrl: run-time-configurable serial bit-pattern match controller.
// Takes a one-shot scan command over cfg_valid/cfg_ready, counts pattern
// hits in a qualified serial stream, and ends the scan on target count,
// timeout or abort with a one-cycle done pulse and a status code.
// Optional build macro: SEQ_MATCH_POS_EN adds the first_pos output.
module seq_match_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int TMO_W   = 16,
  localparam int LEN_W  = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic [TMO_W-1:0]   cfg_timeout,
  input  logic               abort,
  input  logic               bit_valid,
  input  logic               bit_in,
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               done,
`ifdef SEQ_MATCH_POS_EN
  output logic [TMO_W-1:0]   first_pos,
`endif
  output logic [1:0]         done_status
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] ST_TARGET  = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;
  localparam logic [1:0] ST_BADCFG  = 2'b11;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [CNT_W-1:0]   tgt_q, tgt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [TMO_W-1:0]   timer_q, timer_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         status_q, status_d;
`ifdef SEQ_MATCH_POS_EN
  logic [TMO_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]   first_pos_q, first_pos_d;
`endif

  // Helper terms for the bit evaluated at this edge.
  logic [MAX_LEN-1:0] hist_new;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_inc;
  logic [TMO_W-1:0]   timer_inc;
  logic               hit;
  logic               target_hit;
  logic               tmo_hit;
  logic               bad_cfg;

  // Pattern compare: history (including the incoming bit) against the low len bits.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    hist_new   = {hist_q[MAX_LEN-2:0], bit_in};
    fill_inc   = (fill_q == MAX_LEN_L) ? fill_q : fill_q + LEN_W'(1);
    timer_inc  = timer_q + TMO_W'(1);
    hit        = bit_valid && (fill_inc >= len_q) &&
                 ((hist_new & len_mask) == (pat_q & len_mask));
    target_hit = hit && (tgt_q != '0) &&
                 (({1'b0, cnt_q} + (CNT_W+1)'(1)) == {1'b0, tgt_q});
    tmo_hit    = (tmo_q != '0) && (timer_inc == tmo_q);
    bad_cfg    = (cfg_len == '0) || (cfg_len > MAX_LEN_L);
  end

  // Next-state and datapath updates for IDLE / SCAN / DONE.
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    tgt_d    = tgt_q;
    tmo_d    = tmo_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    timer_d  = timer_q;
    match_d  = 1'b0;
    cnt_d    = cnt_q;
    status_d = status_q;
`ifdef SEQ_MATCH_POS_EN
    bit_cnt_d   = bit_cnt_q;
    first_pos_d = first_pos_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          pat_d    = cfg_pattern;
          len_d    = cfg_len;
          ovl_d    = cfg_overlap;
          tgt_d    = cfg_target;
          tmo_d    = cfg_timeout;
          hist_d   = '0;
          fill_d   = '0;
          timer_d  = '0;
          cnt_d    = '0;
          status_d = ST_TARGET;
`ifdef SEQ_MATCH_POS_EN
          bit_cnt_d   = '0;
          first_pos_d = '0;
`endif
          if (bad_cfg) begin
            status_d = ST_BADCFG;
            state_d  = S_DONE;
          end else begin
            state_d  = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        timer_d = timer_inc;
        if (abort) begin
          // The bit presented with abort is dropped.
          status_d = ST_ABORT;
          state_d  = S_DONE;
        end else begin
          if (bit_valid) begin
            hist_d = hist_new;
            fill_d = fill_inc;
`ifdef SEQ_MATCH_POS_EN
            bit_cnt_d = bit_cnt_q + TMO_W'(1);
`endif
            if (hit) begin
              match_d = 1'b1;
              cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
              // Non-overlapping mode: the next match must start from fresh bits.
              if (!ovl_q) fill_d = '0;
`ifdef SEQ_MATCH_POS_EN
              if (cnt_q == '0) first_pos_d = bit_cnt_q + TMO_W'(1);
`endif
            end
          end
          if (target_hit) begin
            status_d = ST_TARGET;
            state_d  = S_DONE;
          end else if (tmo_hit) begin
            status_d = ST_TIMEOUT;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pat_q    <= '0;
      len_q    <= '0;
      ovl_q    <= 1'b0;
      tgt_q    <= '0;
      tmo_q    <= '0;
      hist_q   <= '0;
      fill_q   <= '0;
      timer_q  <= '0;
      match_q  <= 1'b0;
      cnt_q    <= '0;
      status_q <= '0;
`ifdef SEQ_MATCH_POS_EN
      bit_cnt_q   <= '0;
      first_pos_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      state_q  <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      ovl_q    <= ovl_d;
      tgt_q    <= tgt_d;
      tmo_q    <= tmo_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      timer_q  <= timer_d;
      match_q  <= match_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
`ifdef SEQ_MATCH_POS_EN
      bit_cnt_q   <= bit_cnt_d;
      first_pos_q <= first_pos_d;
`endif
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    cfg_ready   = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    match       = match_q;
    match_cnt   = cnt_q;
    done_status = status_q;
`ifdef SEQ_MATCH_POS_EN
    first_pos   = first_pos_q;
`endif
  end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// tb_seq_match_ctrl: table-driven directed bench for seq_match_ctrl.
// Each row gives inputs applied before a rising edge and the outputs
// expected just after it. Reset cases are hand-written sequences.
module tb_seq_match_ctrl;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
  logic [7:0]  cfg_target;
  logic [15:0] cfg_timeout;
  logic        abort;
  logic        bit_valid;
  logic        bit_in;
  logic        busy;
  logic        match;
  logic [7:0]  match_cnt;
  logic        done;
  logic [1:0]  done_status;
`ifdef SEQ_MATCH_POS_EN
  logic [15:0] first_pos;
`endif

  seq_match_ctrl #(.MAX_LEN(8), .CNT_W(8), .TMO_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cfg_target (cfg_target),
    .cfg_timeout(cfg_timeout),
    .abort      (abort),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .busy       (busy),
    .match      (match),
    .match_cnt  (match_cnt),
    .done       (done),
`ifdef SEQ_MATCH_POS_EN
    .first_pos  (first_pos),
`endif
    .done_status(done_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic [7:0]  pat;
    logic [3:0]  len;
    logic        ovl;
    logic [7:0]  tgt;
    logic [15:0] tmo;
    logic        ab;
    logic        bv;
    logic        bi;
    logic        e_busy;
    logic        e_ready;
    logic        e_match;
    logic [7:0]  e_cnt;
    logic        e_done;
    logic [1:0]  e_status;
  } vec_t;

  vec_t tbl[$];

  logic [7:0]  cur_pat;
  logic [3:0]  cur_len;
  logic        cur_ovl;
  logic [7:0]  cur_tgt;
  logic [15:0] cur_tmo;

  int total;
  int bad;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (row %0d): got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic set_cfg(input logic [7:0] pat, input logic [3:0] len,
                         input logic ovl, input logic [7:0] tgt,
                         input logic [15:0] tmo);
    cur_pat = pat;
    cur_len = len;
    cur_ovl = ovl;
    cur_tgt = tgt;
    cur_tmo = tmo;
  endtask

  task automatic add(input logic cv, input logic ab, input logic bv, input logic bi,
                     input logic eb, input logic er, input logic em,
                     input logic [7:0] ec, input logic ed, input logic [1:0] es);
    vec_t v;
    v.cv = cv;  v.pat = cur_pat; v.len = cur_len; v.ovl = cur_ovl;
    v.tgt = cur_tgt; v.tmo = cur_tmo;
    v.ab = ab;  v.bv = bv; v.bi = bi;
    v.e_busy = eb; v.e_ready = er; v.e_match = em;
    v.e_cnt = ec;  v.e_done = ed;  v.e_status = es;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    cfg_valid   = v.cv;
    cfg_pattern = v.pat;
    cfg_len     = v.len;
    cfg_overlap = v.ovl;
    cfg_target  = v.tgt;
    cfg_timeout = v.tmo;
    abort       = v.ab;
    bit_valid   = v.bv;
    bit_in      = v.bi;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      check("busy",        i, 32'(busy),        32'(tbl[i].e_busy));
      check("cfg_ready",   i, 32'(cfg_ready),   32'(tbl[i].e_ready));
      check("match",       i, 32'(match),       32'(tbl[i].e_match));
      check("match_cnt",   i, 32'(match_cnt),   32'(tbl[i].e_cnt));
      check("done",        i, 32'(done),        32'(tbl[i].e_done));
      check("done_status", i, 32'(done_status), 32'(tbl[i].e_status));
    end
  endtask

  int mark_a;
  int mark_c;
  int mark_d;
  int mark_end;
  vec_t idle_v;

  initial begin
    total = 0;
    bad   = 0;
    set_cfg(8'h00, 4'd0, 1'b0, 8'd0, 16'd0);
    add(0, 0, 0, 0, 0, 1, 0, 8'd0, 0, 2'd0);
    idle_v = tbl[0];
    tbl.delete();

    // A: 11011 overlapping, stream 1101_1011 with a bit_valid gap, then abort.
    set_cfg(8'h1B, 4'd5, 1'b1, 8'd0, 16'd0);
    add(1, 0, 0, 0, 1, 0, 0, 8'd0, 0, 2'd0);
    add(0, 0, 1, 1, 1, 0, 0, 8'd0, 0, 2'd0);
    add(0, 0, 1, 1, 1, 0, 0, 8'd0, 0, 2'd0);
    add(0, 0, 1, 0, 1, 0, 0, 8'd0, 0, 2'd0);
    add(0, 0, 1, 1, 1, 0, 0, 8'd0, 0, 2'd0);
    add(0, 0, 1, 1, 1, 0, 1, 8'd1, 0, 2'd0);
    add(1, 0, 0, 0, 1, 0, 0, 8'd1, 0, 2'd0);  // gap; cfg_valid while busy
    add(0, 0, 1, 0, 1, 0, 0, 8'd1, 0, 2'd0);
    add(0, 0, 1, 1, 1, 0, 0, 8'd1, 0, 2'd0);
    add(0, 0, 1, 1, 1, 0, 1, 8'd2, 0, 2'd0);
    add(0, 1, 1, 1, 1, 0, 0, 8'd2, 1, 2'd2);
    add(0, 0, 0, 0, 0, 1, 0, 8'd2, 0, 2'd2);
    mark_a = tbl.size();

    // B: same stream, non-overlapping.
    set_cfg(8'h1B, 4'd5, 1'b0, 8'd0, 16'd0);
    add(1, 0, 0, 0, 1, 0, 0, 8'd0, 0, 2'd0);
    add(0, 0, 1, 1, 1, 0, 0, 8'd0, 0, 2'd0);
    add(0, 0, 1, 1, 1, 0, 0, 8'd0, 0, 2'd0);
    add(0, 0, 1, 0, 1, 0, 0, 8'd0, 0, 2'd0);
    add(0, 0, 1, 1, 1, 0, 0, 8'd0, 0, 2'd0);
    add(0, 0, 1, 1, 1, 0, 1, 8'd1, 0, 2'd0);
    add(0, 0, 1, 0, 1, 0, 0, 8'd1, 0, 2'd0);
    add(0, 0, 1, 1, 1, 0, 0, 8'd1, 0, 2'd0);
    add(0, 0, 1, 1, 1, 0, 0, 8'd1, 0, 2'd0);
    add(0, 1, 0, 0, 1, 0, 0, 8'd1, 1, 2'd2);
    add(0, 0, 0, 0, 0, 1, 0, 8'd1, 0, 2'd2);

    // C: target 2, overlapping; done coincides with the second match.
    set_cfg(8'h1B, 4'd5, 1'b1, 8'd2, 16'd0);
    add(1, 0, 0, 0, 1, 0, 0, 8'd0, 0, 2'd0);
    add(0, 0, 1, 1, 1, 0, 0, 8'd0, 0, 2'd0);
    add(0, 0, 1, 1, 1, 0, 0, 8'd0, 0, 2'd0);
    add(0, 0, 1, 0, 1, 0, 0, 8'd0, 0, 2'd0);
    add(0, 0, 1, 1, 1, 0, 0, 8'd0, 0, 2'd0);
    add(0, 0, 1, 1, 1, 0, 1, 8'd1, 0, 2'd0);
    add(0, 0, 1, 0, 1, 0, 0, 8'd1, 0, 2'd0);
    add(0, 0, 1, 1, 1, 0, 0, 8'd1, 0, 2'd0);
    add(0, 0, 1, 1, 1, 0, 1, 8'd2, 1, 2'd0);
    add(0, 0, 0, 0, 0, 1, 0, 8'd2, 0, 2'd0);
    mark_c = tbl.size();

    // D: timeout 4 on a stream of zeros.
    set_cfg(8'h1B, 4'd5, 1'b1, 8'd0, 16'd4);
    add(1, 0, 0, 0, 1, 0, 0, 8'd0, 0, 2'd0);
    add(0, 0, 1, 0, 1, 0, 0, 8'd0, 0, 2'd0);
    add(0, 0, 1, 0, 1, 0, 0, 8'd0, 0, 2'd0);
    add(0, 0, 1, 0, 1, 0, 0, 8'd0, 0, 2'd0);
    add(0, 0, 1, 0, 1, 0, 0, 8'd0, 1, 2'd1);
    add(0, 0, 0, 0, 0, 1, 0, 8'd0, 0, 2'd1);
    mark_d = tbl.size();

    // E: abort and target hit at the same edge -> abort wins, bit dropped.
    set_cfg(8'h03, 4'd2, 1'b1, 8'd1, 16'd0);
    add(1, 0, 0, 0, 1, 0, 0, 8'd0, 0, 2'd0);
    add(0, 0, 1, 1, 1, 0, 0, 8'd0, 0, 2'd0);
    add(0, 1, 1, 1, 1, 0, 0, 8'd0, 1, 2'd2);
    add(0, 0, 0, 0, 0, 1, 0, 8'd0, 0, 2'd2);

    // F: timeout with a hit in the final cycle still counted.
    set_cfg(8'h01, 4'd1, 1'b1, 8'd0, 16'd2);
    add(1, 0, 0, 0, 1, 0, 0, 8'd0, 0, 2'd0);
    add(0, 0, 1, 1, 1, 0, 1, 8'd1, 0, 2'd0);
    add(0, 0, 1, 1, 1, 0, 1, 8'd2, 1, 2'd1);
    add(0, 0, 0, 0, 0, 1, 0, 8'd2, 0, 2'd1);

    // G: bad config len 0; abort in DONE and IDLE ignored.
    set_cfg(8'h1B, 4'd0, 1'b1, 8'd0, 16'd0);
    add(1, 0, 1, 1, 1, 0, 0, 8'd0, 1, 2'd3);
    add(0, 1, 1, 1, 0, 1, 0, 8'd0, 0, 2'd3);
    add(0, 1, 1, 1, 0, 1, 0, 8'd0, 0, 2'd3);

    // H: bad config len above MAX_LEN.
    set_cfg(8'h1B, 4'd9, 1'b1, 8'd0, 16'd0);
    add(1, 0, 1, 1, 1, 0, 0, 8'd0, 1, 2'd3);
    add(0, 0, 1, 1, 0, 1, 0, 8'd0, 0, 2'd3);
    mark_end = tbl.size();

    // Reset state.
    drive(idle_v);
    rst = 1'b1;
    #2;
    check("rst_busy",      -1, 32'(busy),        32'(0));
    check("rst_ready",     -1, 32'(cfg_ready),   32'(1));
    check("rst_match_cnt", -1, 32'(match_cnt),   32'(0));
    check("rst_done",      -1, 32'(done),        32'(0));
    check("rst_status",    -1, 32'(done_status), 32'(0));
    #10;
    rst = 1'b0;

    run_rows(0, mark_a);
`ifdef SEQ_MATCH_POS_EN
    check("first_pos_a", mark_a, 32'(first_pos), 32'(5));
`endif
    run_rows(mark_a, mark_c);
`ifdef SEQ_MATCH_POS_EN
    check("first_pos_c", mark_c, 32'(first_pos), 32'(5));
`endif
    run_rows(mark_c, mark_d);
`ifdef SEQ_MATCH_POS_EN
    check("first_pos_d", mark_d, 32'(first_pos), 32'(0));
`endif
    run_rows(mark_d, mark_end);

    // Reset mid-scan: single-bit pattern so match and match_cnt are live.
    cfg_valid   = 1'b1;
    cfg_pattern = 8'h01;
    cfg_len     = 4'd1;
    cfg_overlap = 1'b1;
    cfg_target  = 8'd0;
    cfg_timeout = 16'd0;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_match_cnt", -2, 32'(match_cnt), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy",      -2, 32'(busy),      32'(0));
    check("mid_rst_ready",     -2, 32'(cfg_ready), 32'(1));
    check("mid_rst_match_cnt", -2, 32'(match_cnt), 32'(0));
    check("mid_rst_match",     -2, 32'(match),     32'(0));
    check("mid_rst_done",      -2, 32'(done),      32'(0));
    @(posedge clk);
    #1;
    check("mid_rst_done_edge", -2, 32'(done), 32'(0));
    check("mid_rst_busy_edge", -2, 32'(busy), 32'(0));
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_done", -2, 32'(done),      32'(0));
    check("post_rst_cnt",  -2, 32'(match_cnt), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_match_ctrl.md
Name: seq_match_ctrl

Overview:
Run-time-configurable controller for a serial bit-pattern detector (e.g. 11011, overlapping or not). Accepts a one-shot scan command over a valid/ready handshake, then scans a qualified serial bit stream and counts matches. Ends the scan on target count, timeout or abort, and reports status. Sits between the host/config logic and the serial data source; it replaces fixed per-pattern Moore detectors with one sequenced resource.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
CNT_W, 8, width of match counter and target
TMO_W, 16, width of timeout counter (clock cycles)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
cfg_valid  in  1  command valid
cfg_ready  out  1  command ready; high only in IDLE
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is first received, bit [0] last
cfg_len  in  $clog2(MAX_LEN)+1  pattern length in bits
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
cfg_target  in  CNT_W  matches to finish; 0 = unlimited
cfg_timeout  in  TMO_W  SCAN cycle limit; 0 = none
abort  in  1  terminate scan
bit_valid  in  1  bit_in qualifier
bit_in  in  1  serial data
busy  out  1  high in SCAN and DONE
match  out  1  one-cycle match pulse (registered)
match_cnt  out  CNT_W  matches in current/last scan
done  out  1  one-cycle end-of-scan pulse
done_status  out  2  00 target, 01 timeout, 10 abort, 11 bad config

Behaviour:
- Reset (async, immediate): state IDLE; cfg_ready=1; busy, match, done, match_cnt, done_status = 0; history, fill and timeout counters cleared. A reset mid-scan discards the scan; no done is issued.
- FSM states: IDLE, SCAN, DONE.
- IDLE -> SCAN on cfg_valid & cfg_ready. The command is latched and match_cnt, history, fill and timer are cleared at that edge. busy=1 from the next cycle.
- Bad config: cfg_len==0 or cfg_len>MAX_LEN. The command is accepted and goes to DONE with status 11; no bits are consumed.
- SCAN: each edge with bit_valid=1 shifts bit_in into the LSB of the history register, and fill increments, saturating at MAX_LEN.
- Hit: fill (including the new bit) >= len and the low len bits of history == cfg_pattern[len-1:0].
  - On a hit, match=1 for the following cycle and match_cnt increments, saturating at all-ones.
  - Overlap=0: fill is reset to 0 on a hit, so no bit is shared between matches. Overlap=1: history and fill are kept.
- Timer: counts every SCAN cycle. When cfg_timeout!=0 and the count reaches cfg_timeout, the scan ends, status 01. A bit sampled in that final cycle is still evaluated.
- Termination priority at one edge: abort (10) > target reached (00) > timeout (01).
  - Abort: the bit in that cycle is ignored.
  - Target reached: match_cnt+1 == cfg_target with cfg_target != 0.
- DONE: lasts exactly one cycle, with done=1 and done_status valid. Returns to IDLE. On a target finish, done coincides with the final match pulse.
- done_status and match_cnt hold until the next accepted command.
- abort in IDLE/DONE: ignored. bit_valid outside SCAN: ignored.
- cfg_valid while busy: not accepted (cfg_ready=0); the source holds it.

Optional Feature:
SEQ_MATCH_POS_EN
- Defined: adds output first_pos[TMO_W-1:0], the count of bits accepted (1-based) up to and including the completing bit of the first match in the scan. It is 0 if there was no match, is cleared on command accept, and holds after DONE.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: assert rst mid-SCAN -> busy=0, match_cnt=0, cfg_ready=1 immediately, no done pulse.
- Overlap: pattern 5'b11011, len 5, overlap=1, target 0, timeout 0, bits 1,1,0,1,1,0,1,1 -> match after bits 5 and 8, match_cnt=2; abort -> done, status 10.
- Non-overlap: same stream with overlap=0 -> single match after bit 5, match_cnt=1 at abort.
- Target: target=2, overlap=1, stream 11011011 -> done with status 00 in the same cycle as the 2nd match pulse, then cfg_ready=1 next cycle.
- Timeout: timeout=4, stream of zeros -> done status 01 after 4 SCAN cycles, match_cnt=0. Also abort and target hit at the same edge -> status 10.
- Bad config: cfg_len=0 -> accepted, done status 11 one cycle later, no match pulses. With SEQ_MATCH_POS_EN and the overlap stream, first_pos=5.
